// File: rtl/life_step_scheduler_if.sv
// Front-end/engine signal bundle for life_step_scheduler.
// The scheduler is the master: it consumes buttons, switches and acks, and drives the requests and status.
interface life_step_scheduler_if;
  logic [3:0]  switch;
  logic        btn_run;
  logic        btn_step;
  logic        btn_clear;
  logic        step_ack;
  logic        clear_ack;
  logic        step_req;
  logic        clear_req;
  logic [15:0] gen_count;
  logic [29:0] period;
  logic        led;

  modport master (
    input  switch, btn_run, btn_step, btn_clear, step_ack, clear_ack,
    output step_req, clear_req, gen_count, period, led
  );

  modport slave (
    output switch, btn_run, btn_step, btn_clear, step_ack, clear_ack,
    input  step_req, clear_req, gen_count, period, led
  );
endinterface

// File: rtl/life_step_scheduler.sv
// Paces single-generation step requests and board clears for the life engine.
// Counts completed generations and tracks run/pause mode.
module life_step_scheduler #(
  parameter int unsigned BASE_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  life_step_scheduler_if.master bus,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STEP, S_CLEAR} state_e;

  state_e      state_q, state_d;
  logic        led_q, led_d;
  logic [29:0] counter_q, counter_d;
  logic [29:0] period_q, period_d;
  logic [15:0] gen_count_q, gen_count_d;
  logic        clear_pending_q, clear_pending_d;
  logic        step_req_q, step_req_d;
  logic        clear_req_q, clear_req_d;
  logic [2:0]  btn_q, btn_d;
  logic        armed_q;

  logic        press_run, press_step, press_clear;
  logic [29:0] period_calc;

  // Buttons already high when reset releases must not count as presses, so edge
  // detection is held off for the first cycle while btn_q catches up.
  assign btn_d       = {bus.btn_clear, bus.btn_step, bus.btn_run};
  assign press_run   = armed_q & bus.btn_run   & ~btn_q[0];
  assign press_step  = armed_q & bus.btn_step  & ~btn_q[1];
  assign press_clear = armed_q & bus.btn_clear & ~btn_q[2];

  assign period_calc = 30'(BASE_DIV) << (4'd15 - bus.switch);

  // Handshake: a request is held high until its ack is sampled high on a rising
  // edge; the request drops on that same edge, and an ack seen while its request
  // is low is ignored.
  always_comb begin
    state_d         = state_q;
    led_d           = led_q;
    counter_d       = counter_q;
    period_d        = period_q;
    gen_count_d     = gen_count_q;
    clear_pending_d = clear_pending_q;

    case (state_q)
      S_IDLE: begin
        if (press_clear) begin
          state_d = S_CLEAR;
        end else if (press_run) begin
          state_d   = S_WAIT;
          led_d     = 1'b1;
          counter_d = '0;
          period_d  = period_calc;
        end else if (press_step) begin
          state_d = S_STEP;
        end
      end
      S_WAIT: begin
        counter_d = counter_q + 30'd1;
        if (press_clear) begin
          state_d = S_CLEAR;
        end else if (press_run) begin
          state_d = S_IDLE;
          led_d   = 1'b0;
        end else if (counter_q == period_q - 30'd1) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        if (press_clear) begin
          clear_pending_d = 1'b1;
        end else if (press_run) begin
          led_d = ~led_q;
        end
        if (bus.step_ack) begin
          gen_count_d = gen_count_q + 16'd1;
          if (clear_pending_d) begin
            state_d = S_CLEAR;
          end else if (led_d) begin
            state_d   = S_WAIT;
            counter_d = '0;
            period_d  = period_calc;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_CLEAR: begin
        if (press_run) begin
          led_d = ~led_q;
        end
        if (bus.clear_ack) begin
          gen_count_d     = '0;
          clear_pending_d = 1'b0;
          if (led_d) begin
            state_d   = S_WAIT;
            counter_d = '0;
            period_d  = period_calc;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    step_req_d  = (state_d == S_STEP);
    clear_req_d = (state_d == S_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      led_q           <= 1'b0;
      counter_q       <= '0;
      period_q        <= '0;
      gen_count_q     <= '0;
      clear_pending_q <= 1'b0;
      step_req_q      <= 1'b0;
      clear_req_q     <= 1'b0;
      btn_q           <= '0;
      armed_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      led_q           <= led_d;
      counter_q       <= counter_d;
      period_q        <= period_d;
      gen_count_q     <= gen_count_d;
      clear_pending_q <= clear_pending_d;
      step_req_q      <= step_req_d;
      clear_req_q     <= clear_req_d;
      btn_q           <= btn_d;
      armed_q         <= 1'b1;
    end
  end

  assign bus.step_req  = step_req_q;
  assign bus.clear_req = clear_req_q;
  assign bus.gen_count = gen_count_q;
  assign bus.period    = period_q;
  assign bus.led       = led_q;
  assign state_dbg     = state_q;

endmodule
